// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector memory requestor and its beat buffer.
package vmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        READ,
        WRITE,
        RESP
    } state_e;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_UNIT  = 2'd1;

    function automatic int max_beats(input int vreg_bits, input int bus_width);
        return vreg_bits / bus_width;
    endfunction

endpackage

// File: rtl/vreg_beat_buffer.sv
// Holds the latched store vector and slices it per beat; assembles load beats
// into a vector register image whose unfilled slices stay zero.
module vreg_beat_buffer
    import vmem_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int VREG_BITS = 256,
    parameter int BEAT_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 capture,
    input  logic [VREG_BITS-1:0] wrdata_in,
    input  logic [BEAT_W-1:0]    beat,
    input  logic                 fill_en,
    input  logic [BUS_WIDTH-1:0] fill_data,
    output logic [BUS_WIDTH-1:0] beat_data,
    output logic [VREG_BITS-1:0] rd_buf
);

    localparam int NBEATS = max_beats(VREG_BITS, BUS_WIDTH);

    logic [VREG_BITS-1:0] wrdata_q, wrdata_d;
    logic [VREG_BITS-1:0] rdbuf_q, rdbuf_d;

    // The beat index is decoded against each slot so an out-of-range beat
    // can never address past the end of the vector.
    always_comb begin
        wrdata_d  = wrdata_q;
        rdbuf_d   = rdbuf_q;
        beat_data = '0;
        if (capture) begin
            wrdata_d = wrdata_in;
            rdbuf_d  = '0;
        end
        for (int i = 0; i < NBEATS; i++) begin
            if (beat == BEAT_W'(i)) begin
                beat_data = wrdata_q[i*BUS_WIDTH +: BUS_WIDTH];
                if (fill_en) begin
                    rdbuf_d[i*BUS_WIDTH +: BUS_WIDTH] = fill_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrdata_q <= '0;
            rdbuf_q  <= '0;
        end else begin
            wrdata_q <= wrdata_d;
            rdbuf_q  <= rdbuf_d;
        end
    end

    assign rd_buf = rdbuf_q;

endmodule

// File: rtl/vmem_requestor.sv
// Vector-register memory requestor: turns one lane request into a burst of
// memory beats. Optional counters are enabled by defining VMEM_REQ_STATS_EN.
module vmem_requestor
    import vmem_pkg::*;
#(
    parameter int ADDR_RANGE   = 32768,
    parameter int LENGTH_RANGE = 32,
    parameter int BUS_WIDTH    = 32,
    parameter int VREG_BITS    = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_load,
    input  logic [1:0]                      req_mode,
    input  logic [$clog2(ADDR_RANGE)-1:0]   req_addr,
    input  logic [$clog2(LENGTH_RANGE):0]   req_length,
    input  logic [VREG_BITS-1:0]            req_wrdata,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_error,
    output logic [VREG_BITS-1:0]            resp_rddata,
    output logic                            mem_wr,
    output logic                            mem_rd,
    output logic [BUS_WIDTH-1:0]            mem_wrdata,
    output logic [$clog2(ADDR_RANGE)-1:0]   mem_addr,
    output logic [$clog2(LENGTH_RANGE):0]   mem_length,
    output logic [1:0]                      mem_mode,
    output logic                            mem_rddataready,
    input  logic                            mem_ready,
    input  logic                            mem_rddatavalid,
    input  logic [BUS_WIDTH-1:0]            mem_rddata
`ifdef VMEM_REQ_STATS_EN
    ,
    output logic [31:0]                     stat_loads,
    output logic [31:0]                     stat_stores,
    output logic [31:0]                     stat_stall_cycles
`endif
);

    localparam int ADDR_W = $clog2(ADDR_RANGE);
    localparam int LEN_W  = $clog2(LENGTH_RANGE) + 1;
    localparam int MAXB   = max_beats(VREG_BITS, BUS_WIDTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [1:0]          mode_q, mode_d;
    logic                load_q, load_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                rdrdy_q, rdrdy_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_error_q, resp_error_d;
    logic                buf_capture, buf_fill;
    logic                last_beat;
    logic [BUS_WIDTH-1:0] beat_data;

    assign last_beat = (beat_q == len_q - LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        mode_d       = mode_q;
        load_d       = load_q;
        resp_error_d = resp_error_q;
        buf_capture  = 1'b0;
        buf_fill     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d       = req_addr;
                    len_d        = req_length;
                    mode_d       = req_mode;
                    load_d       = req_load;
                    beat_d       = '0;
                    buf_capture  = 1'b1;
                    resp_error_d = 1'b0;
                    if (req_length == '0 || req_length > LEN_W'(MAXB)) begin
                        resp_error_d = 1'b1;
                        state_d      = RESP;
                    end else if (req_load) begin
                        state_d = ISSUE_RD;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            ISSUE_RD: state_d = READ;
            READ: begin
                if (mem_rddatavalid) begin
                    buf_fill = 1'b1;
                    beat_d   = beat_q + LEN_W'(1);
                    if (last_beat) state_d = RESP;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (last_beat) state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they appear registered.
        req_ready_d  = (state_d == IDLE);
        mem_wr_d     = (state_d == WRITE);
        mem_rd_d     = (state_d == ISSUE_RD);
        rdrdy_d      = (state_d == READ);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            mode_q       <= '0;
            load_q       <= 1'b0;
            req_ready_q  <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            rdrdy_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            mode_q       <= mode_d;
            load_q       <= load_d;
            req_ready_q  <= req_ready_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            rdrdy_q      <= rdrdy_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
        end
    end

    vreg_beat_buffer #(
        .BUS_WIDTH (BUS_WIDTH),
        .VREG_BITS (VREG_BITS),
        .BEAT_W    (LEN_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (buf_capture),
        .wrdata_in (req_wrdata),
        .beat      (beat_q),
        .fill_en   (buf_fill),
        .fill_data (mem_rddata),
        .beat_data (beat_data),
        .rd_buf    (resp_rddata)
    );

    assign req_ready       = req_ready_q;
    assign mem_wr          = mem_wr_q;
    assign mem_rd          = mem_rd_q;
    assign mem_rddataready = rdrdy_q;
    assign resp_valid      = resp_valid_q;
    assign resp_error      = resp_error_q;
    assign mem_wrdata      = mem_wr_q ? beat_data : '0;
    assign mem_addr        = addr_q;
    assign mem_length      = len_q;
    assign mem_mode        = mode_q;

`ifdef VMEM_REQ_STATS_EN
    logic [31:0] loads_q, loads_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] stalls_q, stalls_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        stalls_d = stalls_q;
        if (state_q == RESP && resp_ready) begin
            if (load_q) loads_d  = sat_inc(loads_q);
            else        stores_d = sat_inc(stores_q);
        end
        if ((state_q == WRITE && !mem_ready) || (state_q == READ && !mem_rddatavalid)) begin
            stalls_d = sat_inc(stalls_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loads_q  <= '0;
            stores_q <= '0;
            stalls_q <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_loads        = loads_q;
    assign stat_stores       = stores_q;
    assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_vmem_requestor.sv
// Directed bench for vmem_requestor: stores, loads, length errors, response
// backpressure and reset during a load.
module tb_vmem_requestor;
    import vmem_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_load;
    logic [1:0]   req_mode;
    logic [14:0]  req_addr;
    logic [5:0]   req_length;
    logic [255:0] req_wrdata;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_error;
    logic [255:0] resp_rddata;
    logic         mem_wr;
    logic         mem_rd;
    logic [31:0]  mem_wrdata;
    logic [14:0]  mem_addr;
    logic [5:0]   mem_length;
    logic [1:0]   mem_mode;
    logic         mem_rddataready;
    logic         mem_ready;
    logic         mem_rddatavalid;
    logic [31:0]  mem_rddata;
`ifdef VMEM_REQ_STATS_EN
    logic [31:0]  stat_loads;
    logic [31:0]  stat_stores;
    logic [31:0]  stat_stall_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    vmem_requestor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_load        (req_load),
        .req_mode        (req_mode),
        .req_addr        (req_addr),
        .req_length      (req_length),
        .req_wrdata      (req_wrdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_error      (resp_error),
        .resp_rddata     (resp_rddata),
        .mem_wr          (mem_wr),
        .mem_rd          (mem_rd),
        .mem_wrdata      (mem_wrdata),
        .mem_addr        (mem_addr),
        .mem_length      (mem_length),
        .mem_mode        (mem_mode),
        .mem_rddataready (mem_rddataready),
        .mem_ready       (mem_ready),
        .mem_rddatavalid (mem_rddatavalid),
        .mem_rddata      (mem_rddata)
`ifdef VMEM_REQ_STATS_EN
        ,
        .stat_loads        (stat_loads),
        .stat_stores       (stat_stores),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    task automatic send_req(input logic ld, input logic [14:0] addr, input int len,
                            input logic [255:0] wd);
        check("req_ready_idle", 256'(req_ready), 256'(1));
        req_valid  = 1'b1;
        req_load   = ld;
        req_mode   = MODE_UNIT;
        req_addr   = addr;
        req_length = 6'(len);
        req_wrdata = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        check("req_ready_busy", 256'(req_ready), 256'(0));
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", 256'({resp_valid, req_ready}), 256'(2'b01));
    endtask

    int stall_seen;

    task automatic run_store(input int len, input logic [255:0] wd, input bit toggle);
        int c = 0;
        int hs = 0;
        int bad = 0;
        stall_seen = 0;
        send_req(1'b0, 15'h100, len, wd);
        while (hs < len && c < 40) begin
            mem_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (!mem_wr || mem_rd || resp_valid || mem_wrdata != wd[hs*32 +: 32] ||
                mem_addr != 15'h100 || mem_mode != MODE_UNIT || mem_length != 6'(len)) bad++;
            if (!mem_ready) stall_seen++;
            @(negedge clk);
            if (mem_ready) hs++;
            c++;
        end
        mem_ready = 1'b1;
        check("st_handshakes", 256'(hs), 256'(len));
        check("st_beat_protocol", 256'(bad), 256'(0));
        check("st_resp_after_last", 256'({resp_valid, resp_error, mem_wr, mem_rd}), 256'(4'b1000));
        check("st_rddata_zero", resp_rddata, 256'(0));
    endtask

    task automatic run_load(input logic [14:0] addr, input int len, input logic [31:0] base,
                            input int stop_at);
        int c = 0;
        int k = 0;
        int bad = 0;
        send_req(1'b1, addr, len, 256'(0));
        check("ld_issue", 256'({mem_rd, mem_wr, mem_rddataready}), 256'(3'b100));
        @(negedge clk);
        check("ld_single_rd", 256'({mem_rd, mem_rddataready}), 256'(2'b01));
        while (k < stop_at && c < 40) begin
            mem_rddatavalid = (c % 2 == 1);
            mem_rddata      = base + 32'(k);
            if (mem_rd || mem_wr || !mem_rddataready || mem_addr != addr || resp_valid) bad++;
            @(negedge clk);
            if (mem_rddatavalid) k++;
            c++;
        end
        mem_rddatavalid = 1'b0;
        mem_rddata      = '0;
        check("ld_beats", 256'(k), 256'(stop_at));
        check("ld_protocol", 256'(bad), 256'(0));
    endtask

    logic [255:0] wd8;
    logic [255:0] held;
    int           bad_hold;
`ifdef VMEM_REQ_STATS_EN
    logic [31:0]  stall_before;
`endif

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_load        = 1'b0;
        req_mode        = MODE_FIXED;
        req_addr        = '0;
        req_length      = '0;
        req_wrdata      = '0;
        resp_ready      = 1'b0;
        mem_ready       = 1'b1;
        mem_rddatavalid = 1'b0;
        mem_rddata      = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 256'({req_ready, resp_valid, resp_error, mem_wr, mem_rd, mem_rddataready}), 256'(0));
        check("rst_addr_len", 256'({mem_addr, mem_length, mem_mode, mem_wrdata}), 256'(0));
        check("rst_rddata", resp_rddata, 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready), 256'(1));

        // 8-beat store, ready always high
        for (int i = 0; i < 8; i++) wd8[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        run_store(8, wd8, 1'b0);
        finish_resp();

        // 4-beat load, data every other cycle
        run_load(15'h40, 4, 32'hA0, 4);
        check("ld_resp", 256'({resp_valid, resp_error, mem_rddataready}), 256'(3'b100));
        check("ld_rddata", resp_rddata, 256'h000000A3_000000A2_000000A1_000000A0);
        finish_resp();

        // 3-beat store with ready toggling
`ifdef VMEM_REQ_STATS_EN
        stall_before = stat_stall_cycles;
`endif
        run_store(3, 256'h33333333_22222222_11111111, 1'b1);
        check("st3_stall_cycles_seen", 256'(stall_seen), 256'(2));
`ifdef VMEM_REQ_STATS_EN
        check("st3_stat_stalls", 256'(stat_stall_cycles - stall_before), 256'(2));
`endif
        finish_resp();

        // Length errors
        send_req(1'b0, 15'h10, 0, 256'hFFFF);
        check("len0_err", 256'({resp_valid, resp_error, mem_wr, mem_rd}), 256'(4'b1100));
        finish_resp();
        send_req(1'b1, 15'h10, 9, 256'(0));
        check("len9_err", 256'({resp_valid, resp_error, mem_wr, mem_rd, mem_rddataready}), 256'(5'b11000));
        check("len9_rddata", resp_rddata, 256'(0));
        finish_resp();

        // Response held under backpressure
        run_load(15'h200, 2, 32'hC0, 2);
        held = resp_rddata;
        check("bp_rddata", held, 256'h000000C1_000000C0);
        bad_hold = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_error || req_ready || resp_rddata != held) bad_hold++;
        end
        check("bp_stable", 256'(bad_hold), 256'(0));
        finish_resp();

        // Reset in the middle of a 4-beat load
        run_load(15'h40, 4, 32'hD0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 256'({req_ready, resp_valid, mem_rddataready, mem_rd, mem_wr}), 256'(0));
        check("midrst_data", 256'({mem_addr, mem_length, mem_mode}), 256'(0));
        check("midrst_rddata", resp_rddata, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", 256'({req_ready, resp_valid}), 256'(2'b10));
        run_load(15'h40, 4, 32'hB0, 4);
        check("reload_rddata", resp_rddata, 256'h000000B3_000000B2_000000B1_000000B0);
        finish_resp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
